// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int BOOTH_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t EVAL  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam logic [1:0] BOOTH_SUB = 2'b10;
    localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_addsub.sv
// Booth step: add, subtract or pass the multiplicand, modulo 2^(WIDTH+1).
module booth_addsub
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] m_i,
    input  logic [1:0]     sel_i,
    output logic [WIDTH:0] y_o
);

    always_comb begin
        y_o = a_i;
        case (sel_i)
            BOOTH_SUB: y_o = a_i - m_i;
            BOOTH_ADD: y_o = a_i + m_i;
            default:   y_o = a_i;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one evaluate and one shift cycle
// per multiplier bit, registered product and one-cycle done pulse.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH:0]       acc,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic                 q1_q, q1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       sum;

    booth_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i   (a_q),
        .m_i   (m_q),
        .sel_i ({qr_q[0], q1_q}),
        .y_o   (sum)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    qr_d    = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                a_d     = sum;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Arithmetic right shift of the {A, Q, q_1} chain.
                a_d   = {a_q[WIDTH], a_q[WIDTH:1]};
                qr_d  = {a_q[0], qr_q[WIDTH-1:1]};
                q1_d  = qr_q[0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d  = {a_q, qr_q[WIDTH-1:1]};
                    state_d = DONE;
                end else begin
                    state_d = EVAL;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign acc     = a_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl at WIDTH = 4.
module tb_booth_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [4:0] acc;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    booth_seq_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .acc          (acc),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then follow edges 1..9.
    task automatic run_op(input string tag, input logic [3:0] m,
                          input logic [3:0] q, input logic [7:0] exp_p,
                          input logic [4:0] exp_a, input int mid_k,
                          input logic [4:0] mid_a);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = ~q;
        chk({tag, " busy0"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == mid_k) chk({tag, " acc_mid"}, 32'(acc), 32'(mid_a));
            if (k < 8) begin
                chk({tag, " done_lo"}, 32'(done), 32'd0);
                chk({tag, " busy"}, 32'(busy), 32'd1);
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy8"}, 32'(busy), 32'd1);
        chk({tag, " product"}, 32'(product), 32'(exp_p));
        chk({tag, " acc"}, 32'(acc), 32'(exp_a));
        tick();
        chk({tag, " done_end"}, 32'(done), 32'd0);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " product_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b1;
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        tick();
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst acc", 32'(acc), 32'd0);
        chk("rst product", 32'(product), 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        tick();
        chk("idle busy", 32'(busy), 32'd0);

        run_op("3x5", 4'd3, 4'd5, 8'h0F, 5'h00, 0, 5'h00);
        run_op("m3x5", 4'hD, 4'd5, 8'hF1, 5'h1F, 0, 5'h00);
        run_op("7xm8", 4'd7, 4'h8, 8'hC8, 5'h1C, 0, 5'h00);
        run_op("m8xm8", 4'h8, 4'h8, 8'h40, 5'h04, 7, 5'h08);

        // Reset lands on edge 4 of an in-flight operation.
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort product", 32'(product), 32'd0);
        chk("abort acc", 32'(acc), 32'd0);
        rst = 1'b1;
        run_op("2x2", 4'd2, 4'd2, 8'h04, 5'h00, 0, 5'h00);

        // Start held high; operands change while busy.
        multiplicand = 4'd1;
        multiplier   = 4'hF;
        start        = 1'b1;
        tick();
        multiplicand = 4'd7;
        multiplier   = 4'd3;
        for (int k = 1; k <= 8; k++) tick();
        chk("hold done", 32'(done), 32'd1);
        chk("hold product", 32'(product), 32'h0000_00FF);
        tick();
        chk("hold idle", 32'(busy), 32'd0);
        tick();
        chk("hold reaccept", 32'(busy), 32'd1);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        chk("hold2 done", 32'(done), 32'd1);
        chk("hold2 product", 32'(product), 32'h0000_0015);
        chk("hold2 acc", 32'(acc), 32'h0000_0001);
        tick();

        run_op("0x0", 4'd0, 4'd0, 8'h00, 5'h00, 0, 5'h00);
        run_op("5xm1", 4'd5, 4'hF, 8'hFB, 5'h1F, 0, 5'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
